// File: rtl/mvb_rx_frame_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : mvb_rx_frame_collector_if
// Purpose  : Bundles the decoder-side FIFO/flag signals and the readout and
//            status signals of the MVB receive frame collector.
// Revision : 1.0 - initial release
// ============================================================================
interface mvb_rx_frame_collector_if;
  // Decoder side
  logic        frame_over;
  logic [4:0]  word_count;
  logic        length_error;
  logic        signal_error;
  logic        delimiter_error;
  logic        quality_error;
  logic        crc_error;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rden;
  // Readout / status side
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        frame_valid;
  logic [6:0]  status;
  logic        pattern_ok;
  logic [7:0]  frame_cnt;
  logic [7:0]  err_cnt;
  logic        busy;

  // Decoder plus readout consumer, seen from outside the collector
  modport master (
    output frame_over, word_count, length_error, signal_error,
           delimiter_error, quality_error, crc_error, fifo_data, fifo_empty,
           rd_addr,
    input  fifo_rden, rd_data, frame_valid, status, pattern_ok, frame_cnt,
           err_cnt, busy
  );

  // The collector itself
  modport slave (
    input  frame_over, word_count, length_error, signal_error,
           delimiter_error, quality_error, crc_error, fifo_data, fifo_empty,
           rd_addr,
    output fifo_rden, rd_data, frame_valid, status, pattern_ok, frame_cnt,
           err_cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/mvb_rx_frame_collector.sv
`default_nettype none
// ============================================================================
// Module   : mvb_rx_frame_collector
// Purpose  : On each MVB decoder end-of-frame, drains the decoder FIFO into a
//            local word buffer, latches the error flags, checks the words
//            against the self-test ramp and keeps frame/error counters.
// Revision : 1.0 - initial release
// ============================================================================
module mvb_rx_frame_collector #(
  parameter int MAX_WORDS = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                    clk_24M,
  input  logic                    rst,
  mvb_rx_frame_collector_if.slave bus
);

  localparam int              c_addr_w   = $clog2(MAX_WORDS);
  localparam int              c_tmo_w    = $clog2(TIMEOUT + 1);
  localparam logic [4:0]      c_max_len  = 5'(MAX_WORDS);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 fo_q;
  logic [4:0]           len_q;
  logic [4:0]           issued_q;
  logic [4:0]           recvd_q;
  logic                 match_q;
  logic [c_tmo_w-1:0]   tmo_q;
  logic [6:0]           stat_q;      // working status of the frame in progress
  logic                 pend_q;      // a FIFO read was issued last cycle
  logic [6:0]           status_q;    // status reported for the last frame
  logic                 pattern_ok_q;
  logic [7:0]           frame_cnt_q;
  logic [7:0]           err_cnt_q;
  logic [15:0]          rd_data_q;
  logic [15:0]          buf_q [MAX_WORDS];

  logic                 w_fo_rise;
  logic                 w_len_bad;
  logic [4:0]           w_flags;
  logic                 w_issue_ok;
  logic                 w_empty_wait;
  logic                 w_capture;
  logic [4:0]           w_recvd_nxt;
  logic [15:0]          w_expect;
  logic [6:0]           w_stat_fin;
  logic                 w_rden;
  logic                 w_timeout;

  assign w_fo_rise    = bus.frame_over & ~fo_q;
  assign w_len_bad    = (bus.word_count == 5'd0) || (bus.word_count > c_max_len);
  assign w_flags      = {bus.crc_error, bus.quality_error, bus.delimiter_error,
                         bus.signal_error, bus.length_error | w_len_bad};
  assign w_issue_ok   = (issued_q < len_q);
  assign w_empty_wait = bus.fifo_empty & w_issue_ok;
  // Data returned by the FIFO is only kept while collecting; DRAIN discards it
  assign w_capture    = pend_q & (state_q == S_READ);
  assign w_recvd_nxt  = recvd_q + 5'd1;
  assign w_expect     = {11'd0, recvd_q} * 16'h1111;
  // An edge arriving in the DONE cycle itself still counts as an overrun
  assign w_stat_fin   = stat_q | (w_fo_rise ? 7'h40 : 7'h00);

  // State register
  always_ff @(posedge clk_24M) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and FIFO read-enable decode; rden is decoded from registered
  // state and the live empty flag so the decoder FIFO never sees a read while
  // empty and never gives up more than len words
  always_comb begin
    state_d   = state_q;
    w_rden    = 1'b0;
    w_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_fo_rise) state_d = (|w_flags) ? S_DRAIN : S_READ;
      end
      S_READ: begin
        w_rden = w_issue_ok & ~bus.fifo_empty;
        if (w_capture && (w_recvd_nxt == len_q)) begin
          state_d = S_DONE;
        end else if (w_empty_wait && (tmo_q == c_tmo_last)) begin
          w_timeout = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DRAIN: begin
        w_rden = ~bus.fifo_empty;
        if (bus.fifo_empty && !pend_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Frame bookkeeping, status reporting, counters and registered readout
  always_ff @(posedge clk_24M) begin
    if (!rst) begin
      fo_q         <= 1'b0;
      len_q        <= 5'd0;
      issued_q     <= 5'd0;
      recvd_q      <= 5'd0;
      match_q      <= 1'b0;
      tmo_q        <= '0;
      stat_q       <= 7'd0;
      pend_q       <= 1'b0;
      status_q     <= 7'd0;
      pattern_ok_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
      err_cnt_q    <= 8'd0;
      rd_data_q    <= 16'd0;
    end else begin
      fo_q      <= bus.frame_over;
      pend_q    <= w_rden;
      rd_data_q <= buf_q[bus.rd_addr[c_addr_w-1:0]];

      case (state_q)
        S_IDLE: begin
          if (w_fo_rise) begin
            stat_q   <= {2'b00, w_flags};
            len_q    <= bus.word_count;
            issued_q <= 5'd0;
            recvd_q  <= 5'd0;
            match_q  <= 1'b1;
            tmo_q    <= '0;
          end
        end
        S_READ: begin
          if (w_rden) begin
            issued_q <= issued_q + 5'd1;
            tmo_q    <= '0;
          end else if (w_empty_wait) begin
            tmo_q    <= tmo_q + 1'b1;
          end
          if (w_capture) begin
            recvd_q <= w_recvd_nxt;
            match_q <= match_q & (bus.fifo_data == w_expect);
          end
          if (w_timeout) stat_q[5] <= 1'b1;
        end
        S_DONE: begin
          status_q     <= w_stat_fin;
          pattern_ok_q <= match_q & (w_stat_fin == 7'd0);
          if (frame_cnt_q != 8'hFF) frame_cnt_q <= frame_cnt_q + 8'd1;
          if ((w_stat_fin != 7'd0) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
        end
        default: ;
      endcase

      // Edges outside IDLE are dropped, only flagged
      if (w_fo_rise && (state_q != S_IDLE)) stat_q[6] <= 1'b1;
    end
  end

  // Word buffer; not reset so the last frame survives a reset
  always_ff @(posedge clk_24M) begin
    if (w_capture) buf_q[recvd_q[c_addr_w-1:0]] <= bus.fifo_data;
  end

  assign bus.fifo_rden   = w_rden;
  assign bus.frame_valid = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.status      = status_q;
  assign bus.pattern_ok  = pattern_ok_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.rd_data     = rd_data_q;

endmodule
`default_nettype wire
